// File: rtl/ex_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage_if
// Brief    : ID/EX-to-EX/MEM bundle for the RV32I execute stage. Optional
//            branch statistics ports exist only with EX_BRANCH_STATS_EN.
// Revision : 1.0
// ============================================================================
interface ex_mem_stage_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  logic [XLEN-1:0] RD1E, RD2E, ExtImmE, PCE, PCPlus4E, ResultW;
  logic [REGW-1:0] Rs1E, Rs2E, RdE;
  logic [2:0]      ALUControlE, funct3E;
  logic            ALUSrcE, BranchE, JumpE, JalrE, LuiE, RegWriteE, MemWriteE;
  logic [1:0]      ResultSrcE, ForwardAE, ForwardBE;

  logic [1:0]      PCSrcE;
  logic [XLEN-1:0] PCTargetE, JalrTargetE;
  logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [REGW-1:0] RdM;
  logic [1:0]      ResultSrcM;
  logic            RegWriteM, MemWriteM;
`ifdef EX_BRANCH_STATS_EN
  logic [XLEN-1:0] BranchCountM, TakenCountM;
`endif

  modport master (
    output RD1E, RD2E, ExtImmE, PCE, PCPlus4E, ResultW, Rs1E, Rs2E, RdE,
           ALUControlE, funct3E, ALUSrcE, BranchE, JumpE, JalrE, LuiE,
           RegWriteE, MemWriteE, ResultSrcE, ForwardAE, ForwardBE,
    input  PCSrcE, PCTargetE, JalrTargetE, ALUResultM, WriteDataM, PCPlus4M,
           RdM, ResultSrcM, RegWriteM, MemWriteM
`ifdef EX_BRANCH_STATS_EN
    , input BranchCountM, TakenCountM
`endif
  );

  modport slave (
    input  RD1E, RD2E, ExtImmE, PCE, PCPlus4E, ResultW, Rs1E, Rs2E, RdE,
           ALUControlE, funct3E, ALUSrcE, BranchE, JumpE, JalrE, LuiE,
           RegWriteE, MemWriteE, ResultSrcE, ForwardAE, ForwardBE,
    output PCSrcE, PCTargetE, JalrTargetE, ALUResultM, WriteDataM, PCPlus4M,
           RdM, ResultSrcM, RegWriteM, MemWriteM
`ifdef EX_BRANCH_STATS_EN
    , output BranchCountM, TakenCountM
`endif
  );
endinterface
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Brief    : RV32I execute stage (forwarding, ALU, branch/jump resolution)
//            plus EX/MEM pipeline register. Macro EX_BRANCH_STATS_EN adds
//            saturating branch / taken counters.
// Revision : 1.0
// ============================================================================
module ex_mem_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic          clk,
  input  logic          rst,
  ex_mem_stage_if.slave bus
);
  localparam int         SHW         = $clog2(XLEN);
  localparam logic [1:0] C_FWD_W     = 2'b01;
  localparam logic [1:0] C_FWD_M     = 2'b10;
  localparam logic [1:0] C_PC_SEQ    = 2'b00;
  localparam logic [1:0] C_PC_TARGET = 2'b01;
  localparam logic [1:0] C_PC_JALR   = 2'b10;
  localparam logic [2:0] C_OP_ADD    = 3'b000;
  localparam logic [2:0] C_OP_SUB    = 3'b001;
  localparam logic [2:0] C_OP_AND    = 3'b010;
  localparam logic [2:0] C_OP_OR     = 3'b011;
  localparam logic [2:0] C_OP_XOR    = 3'b100;
  localparam logic [2:0] C_OP_SLT    = 3'b101;
  localparam logic [2:0] C_OP_SLTU   = 3'b110;

  logic [XLEN-1:0] alu_result_q, write_data_q, pc_plus4_q;
  logic [REGW-1:0] rd_q;
  logic [1:0]      result_src_q;
  logic            reg_write_q, mem_write_q;

  logic [XLEN-1:0] alu_result_d, write_data_d;
  logic [XLEN-1:0] w_src_a, w_src_b, w_alu_out;
  logic            w_branch_taken;
  logic [1:0]      w_pc_src;
  logic            w_unused;

  // Rs1E/Rs2E are consumed by the hazard unit, not here.
  assign w_unused = ^{bus.Rs1E, bus.Rs2E};

  // ALUResultM forwards from this block's own registered output.
  always_comb begin
    case (bus.ForwardAE)
      C_FWD_W: w_src_a = bus.ResultW;
      C_FWD_M: w_src_a = alu_result_q;
      default: w_src_a = bus.RD1E;
    endcase
    case (bus.ForwardBE)
      C_FWD_W: write_data_d = bus.ResultW;
      C_FWD_M: write_data_d = alu_result_q;
      default: write_data_d = bus.RD2E;
    endcase
  end

  assign w_src_b = bus.ALUSrcE ? bus.ExtImmE : write_data_d;

  always_comb begin
    case (bus.ALUControlE)
      C_OP_ADD:  w_alu_out = w_src_a + w_src_b;
      C_OP_SUB:  w_alu_out = w_src_a - w_src_b;
      C_OP_AND:  w_alu_out = w_src_a & w_src_b;
      C_OP_OR:   w_alu_out = w_src_a | w_src_b;
      C_OP_XOR:  w_alu_out = w_src_a ^ w_src_b;
      C_OP_SLT:  w_alu_out = {{(XLEN-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
      C_OP_SLTU: w_alu_out = {{(XLEN-1){1'b0}}, (w_src_a < w_src_b)};
      default:   w_alu_out = w_src_a >> w_src_b[SHW-1:0];
    endcase
  end

  assign alu_result_d = bus.LuiE ? bus.ExtImmE : w_alu_out;

  // Branch conditions compare register operands, never the immediate.
  always_comb begin
    case (bus.funct3E)
      3'b000:  w_branch_taken = (w_src_a == write_data_d);
      3'b001:  w_branch_taken = (w_src_a != write_data_d);
      3'b100:  w_branch_taken = ($signed(w_src_a) <  $signed(write_data_d));
      3'b101:  w_branch_taken = ($signed(w_src_a) >= $signed(write_data_d));
      3'b110:  w_branch_taken = (w_src_a <  write_data_d);
      3'b111:  w_branch_taken = (w_src_a >= write_data_d);
      default: w_branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    if (bus.JumpE && bus.JalrE)
      w_pc_src = C_PC_JALR;
    else if (bus.JumpE || (bus.BranchE && w_branch_taken))
      w_pc_src = C_PC_TARGET;
    else
      w_pc_src = C_PC_SEQ;
  end

  assign bus.PCSrcE      = w_pc_src;
  assign bus.PCTargetE   = bus.PCE + bus.ExtImmE;
  assign bus.JalrTargetE = {alu_result_d[XLEN-1:1], 1'b0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
      result_src_q <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= bus.PCPlus4E;
      rd_q         <= bus.RdE;
      result_src_q <= bus.ResultSrcE;
      reg_write_q  <= bus.RegWriteE;
      mem_write_q  <= bus.MemWriteE;
    end
  end

  assign bus.ALUResultM = alu_result_q;
  assign bus.WriteDataM = write_data_q;
  assign bus.PCPlus4M   = pc_plus4_q;
  assign bus.RdM        = rd_q;
  assign bus.ResultSrcM = result_src_q;
  assign bus.RegWriteM  = reg_write_q;
  assign bus.MemWriteM  = mem_write_q;

`ifdef EX_BRANCH_STATS_EN
  logic [XLEN-1:0] branch_count_q, taken_count_q;

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_count_q <= '0;
      taken_count_q  <= '0;
    end else begin
      if (bus.BranchE && !(&branch_count_q))
        branch_count_q <= branch_count_q + 1'b1;
      if ((w_pc_src != C_PC_SEQ) && !(&taken_count_q))
        taken_count_q <= taken_count_q + 1'b1;
    end
  end

  assign bus.BranchCountM = branch_count_q;
  assign bus.TakenCountM  = taken_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage
// Brief    : Directed bench for ex_mem_stage with a behavioural reference
//            model checked every falling edge. Honours EX_BRANCH_STATS_EN.
// Revision : 1.0
// ============================================================================
module tb_ex_mem_stage;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [1:0]  pcsrc;
    logic [31:0] pct;
    logic [31:0] jt;
  } ex_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic cmp_en = 1'b0;

  ex_mem_stage_if #(.XLEN(XLEN), .REGW(REGW)) bus ();

  ex_mem_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state (expected EX/MEM contents and counters)
  logic [31:0] m_alu, m_wd, m_pc4, m_bc, m_tc;
  logic [4:0]  m_rd;
  logic [1:0]  m_rs;
  logic        m_rw, m_mw;
  ex_t         nx;

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r,
                                       input logic [31:0] w, input logic [31:0] m);
    if (sel == 2'd1) return w;
    if (sel == 2'd2) return m;
    return r;
  endfunction

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned m32 = 64'h1_0000_0000;
    case (op)
      3'd0: return 32'((ua + ub) % m32);
      3'd1: return 32'((ua + m32 - ub) % m32);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return (ua < ub) ? 32'd1 : 32'd0;
      default: return 32'(ua / (64'd1 << (ub % 32)));
    endcase
  endfunction

  function automatic logic taken_model(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ex_t ex_model(input logic [31:0] fwd_m);
    ex_t         e;
    logic [31:0] a, b;
    a    = pick(bus.ForwardAE, bus.RD1E, bus.ResultW, fwd_m);
    e.wd = pick(bus.ForwardBE, bus.RD2E, bus.ResultW, fwd_m);
    b    = bus.ALUSrcE ? bus.ExtImmE : e.wd;
    e.alu = bus.LuiE ? bus.ExtImmE : alu_model(bus.ALUControlE, a, b);
    if (!bus.JumpE) e.pcsrc = (bus.BranchE && taken_model(bus.funct3E, a, e.wd)) ? 2'd1 : 2'd0;
    else            e.pcsrc = bus.JalrE ? 2'd2 : 2'd1;
    e.pct = 32'((64'(bus.PCE) + 64'(bus.ExtImmE)) % 64'h1_0000_0000);
    e.jt  = (e.alu / 2) * 2;
    return e;
  endfunction

  always_comb nx = ex_model(m_alu);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_alu <= '0; m_wd <= '0; m_pc4 <= '0; m_rd <= '0; m_rs <= '0;
      m_rw <= 1'b0; m_mw <= 1'b0; m_bc <= '0; m_tc <= '0;
    end else begin
      m_alu <= nx.alu;
      m_wd  <= nx.wd;
      m_pc4 <= bus.PCPlus4E;
      m_rd  <= bus.RdE;
      m_rs  <= bus.ResultSrcE;
      m_rw  <= bus.RegWriteE;
      m_mw  <= bus.MemWriteE;
      if (bus.BranchE && m_bc != 32'hFFFF_FFFF) m_bc <= m_bc + 32'd1;
      if (nx.pcsrc != 2'd0 && m_tc != 32'hFFFF_FFFF) m_tc <= m_tc + 32'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("PCSrcE",      32'(bus.PCSrcE),      32'(nx.pcsrc));
        check("PCTargetE",   bus.PCTargetE,        nx.pct);
        check("JalrTargetE", bus.JalrTargetE,      nx.jt);
        check("ALUResultM",  bus.ALUResultM,       m_alu);
        check("WriteDataM",  bus.WriteDataM,       m_wd);
        check("PCPlus4M",    bus.PCPlus4M,         m_pc4);
        check("RdM",         32'(bus.RdM),         32'(m_rd));
        check("ResultSrcM",  32'(bus.ResultSrcM),  32'(m_rs));
        check("RegWriteM",   32'(bus.RegWriteM),   32'(m_rw));
        check("MemWriteM",   32'(bus.MemWriteM),   32'(m_mw));
`ifdef EX_BRANCH_STATS_EN
        check("BranchCountM", bus.BranchCountM, m_bc);
        check("TakenCountM",  bus.TakenCountM,  m_tc);
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle();
    bus.RD1E = '0; bus.RD2E = '0; bus.ExtImmE = '0; bus.PCE = '0; bus.PCPlus4E = '0;
    bus.ResultW = '0; bus.Rs1E = '0; bus.Rs2E = '0; bus.RdE = '0;
    bus.ALUControlE = '0; bus.funct3E = 3'b010; bus.ALUSrcE = 1'b0; bus.BranchE = 1'b0;
    bus.JumpE = 1'b0; bus.JalrE = 1'b0; bus.LuiE = 1'b0; bus.RegWriteE = 1'b0;
    bus.MemWriteE = 1'b0; bus.ResultSrcE = '0; bus.ForwardAE = '0; bus.ForwardBE = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_m_zero(input string tag);
    check({tag, ".ALUResultM"}, bus.ALUResultM, 32'd0);
    check({tag, ".WriteDataM"}, bus.WriteDataM, 32'd0);
    check({tag, ".PCPlus4M"},   bus.PCPlus4M,   32'd0);
    check({tag, ".RdM"},        32'(bus.RdM),   32'd0);
    check({tag, ".ResultSrcM"}, 32'(bus.ResultSrcM), 32'd0);
    check({tag, ".RegWriteM"},  32'(bus.RegWriteM),  32'd0);
    check({tag, ".MemWriteM"},  32'(bus.MemWriteM),  32'd0);
  endtask

  initial begin : stim
    logic [31:0] opa [4];
    logic [31:0] opb [4];
    opa[0] = 32'd5;         opb[0] = 32'd7;
    opa[1] = 32'h8000_0000; opb[1] = 32'd1;
    opa[2] = 32'd7;         opb[2] = 32'd7;
    opa[3] = 32'hFFFF_FFF0; opb[3] = 32'd10;

    idle();
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    bus.RD1E = 32'd9; bus.RD2E = 32'd3; bus.RegWriteE = 1'b1; bus.MemWriteE = 1'b1;
    bus.RdE = 5'd4; bus.PCPlus4E = 32'h44; bus.ResultSrcE = 2'd1;
    step();
    check_m_zero("in_reset");
    rst = 1'b1;

    // first capture after release
    idle();
    bus.RD1E = 32'd5; bus.RD2E = 32'd7; bus.RdE = 5'd3;
    step();
    check("first.ALUResultM", bus.ALUResultM, 32'd12);
    check("first.RdM", 32'(bus.RdM), 32'd3);

    // forwarding from ALUResultM and ResultW
    idle(); bus.RD1E = 32'h40;
    step();
    idle();
    bus.RD1E = 32'd1; bus.ForwardAE = 2'b10; bus.ALUSrcE = 1'b1; bus.ExtImmE = 32'd4;
    bus.ForwardBE = 2'b01; bus.ResultW = 32'd9; bus.RD2E = 32'd2; bus.MemWriteE = 1'b1;
    step();
    check("fwdA.ALUResultM", bus.ALUResultM, 32'h44);
    check("fwdB.WriteDataM", bus.WriteDataM, 32'd9);

    // signed vs unsigned compare and branch
    idle();
    bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 32'd1; bus.ALUSrcE = 1'b1; bus.ExtImmE = 32'd1;
    bus.ALUControlE = 3'b101; bus.BranchE = 1'b1; bus.funct3E = 3'b100;
    #1 check("blt.PCSrcE", 32'(bus.PCSrcE), 32'd1);
    step();
    check("slt.ALUResultM", bus.ALUResultM, 32'd1);
    bus.ALUControlE = 3'b110; bus.funct3E = 3'b110;
    #1 check("bltu.PCSrcE", 32'(bus.PCSrcE), 32'd0);
    step();
    check("sltu.ALUResultM", bus.ALUResultM, 32'd0);

    // jal and jalr
    idle();
    bus.PCE = 32'h100; bus.ExtImmE = 32'h20; bus.JumpE = 1'b1;
    #1 check("jal.PCSrcE", 32'(bus.PCSrcE), 32'd1);
    check("jal.PCTargetE", bus.PCTargetE, 32'h120);
    step();
    idle();
    bus.RD1E = 32'h203; bus.ALUSrcE = 1'b1; bus.JumpE = 1'b1; bus.JalrE = 1'b1;
    bus.PCPlus4E = 32'h104; bus.RegWriteE = 1'b1; bus.RdE = 5'd1; bus.ResultSrcE = 2'd2;
    #1 check("jalr.PCSrcE", 32'(bus.PCSrcE), 32'd2);
    check("jalr.JalrTargetE", bus.JalrTargetE, 32'h202);
    step();
    check("jalr.PCPlus4M", bus.PCPlus4M, 32'h104);
    check("jalr.ResultSrcM", 32'(bus.ResultSrcM), 32'd2);

    // LUI, wraparound, shift
    idle(); bus.LuiE = 1'b1; bus.ExtImmE = 32'h1234_5000; bus.RD1E = 32'd7;
    step();
    check("lui.ALUResultM", bus.ALUResultM, 32'h1234_5000);
    idle(); bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 32'd1;
    step();
    check("wrap.ALUResultM", bus.ALUResultM, 32'd0);
    idle(); bus.RD1E = 32'h8000_0000; bus.ALUSrcE = 1'b1; bus.ExtImmE = 32'd31;
    bus.ALUControlE = 3'b111;
    step();
    check("srl.ALUResultM", bus.ALUResultM, 32'd1);

    // sweep of ALU ops x branch conditions x forwarding selects
    for (int i = 0; i < 64; i++) begin
      idle();
      bus.ALUControlE = 3'(i % 8);
      bus.funct3E     = 3'(i / 8);
      bus.RD1E        = opa[i % 4];
      bus.RD2E        = opb[i % 4];
      bus.ForwardAE   = 2'((i / 3) % 4);
      bus.ForwardBE   = 2'((i / 5) % 4);
      bus.ResultW     = 32'h55 + 32'(i);
      bus.ALUSrcE     = i[2];
      bus.ExtImmE     = 32'h21 + 32'(i);
      bus.BranchE     = 1'b1;
      bus.PCE         = 32'h1000 + 32'(4 * i);
      bus.PCPlus4E    = 32'h1004 + 32'(4 * i);
      bus.RdE         = 5'(i);
      bus.ResultSrcE  = 2'(i % 3);
      bus.RegWriteE   = i[0];
      bus.MemWriteE   = i[1];
      step();
    end

    // asynchronous reset in the middle of a cycle
    idle(); bus.RD1E = 32'd3; bus.RegWriteE = 1'b1; bus.RdE = 5'd7; bus.PCPlus4E = 32'h8;
    step();
    #2 rst = 1'b0;
    #1 check_m_zero("async_rst");
    idle();
    step();
    rst = 1'b1;

`ifdef EX_BRANCH_STATS_EN
    idle(); bus.RD1E = 32'd3; bus.RD2E = 32'd3; bus.BranchE = 1'b1; bus.funct3E = 3'b000;
    step();
    bus.funct3E = 3'b001;
    step();
    bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 32'd1; bus.funct3E = 3'b100;
    step();
    idle(); bus.JumpE = 1'b1;
    step();
    idle();
    step();
    check("stats.BranchCountM", bus.BranchCountM, 32'd3);
    check("stats.TakenCountM",  bus.TakenCountM,  32'd3);
    #2 rst = 1'b0;
    #1 check("stats_rst.BranchCountM", bus.BranchCountM, 32'd0);
    check("stats_rst.TakenCountM", bus.TakenCountM, 32'd0);
    step();
    rst = 1'b1;
`endif

    step();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
